// File: rtl/switch_input_pkg.sv
// Shared constants for the switch/key input controller: input counts,
// read-select codes and the default debounce length.
package switch_input_pkg;

   localparam int NUM_SW  = 10;
   localparam int NUM_KEY = 2;

   localparam logic [1:0] SEL_SW    = 2'd0;
   localparam logic [1:0] SEL_KEY   = 2'd1;
   localparam logic [1:0] SEL_EVENT = 2'd2;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/input_debouncer.sv
// One-bit input conditioner: 2-flop synchroniser followed by a debounce
// counter that only accepts a level after DEBOUNCE_CYCLES stable cycles.
module input_debouncer
   import switch_input_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic q_out
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;

   // The counter clears at CNT_MAX, so it can never wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= RESET_VAL;
         r_sync2  <= RESET_VAL;
         r_stable <= RESET_VAL;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= d_in;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_stable) begin
            if (r_cnt == CNT_MAX) begin
               r_stable <= r_sync2;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign q_out = r_stable;

endmodule

// File: rtl/switch_input_controller.sv
// Debounced slide-switch / push-button front end with a registered read port.
// Define SWITCH_INPUT_EVENT_LATCH_EN to add the sticky key-press event register.
module switch_input_controller
   import switch_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SW-1:0]  sw_in,
   input  logic [NUM_KEY-1:0] key_in,
   input  logic               rd_en,
   input  logic [1:0]         rd_sel,
   output logic [31:0]        rd_data,
   output logic [NUM_SW-1:0]  sw_stable,
   output logic [NUM_KEY-1:0] key_pressed
);

   logic [NUM_KEY-1:0] w_key_stable;
   logic [NUM_KEY-1:0] w_key_event;
   logic [31:0]        w_rd_mux;
   logic [31:0]        r_rd_data;

   for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
      input_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (1'b0)
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .d_in  (sw_in[gi]),
         .q_out (sw_stable[gi])
      );
   end

   // Keys are active-low; resetting their flops to 1 means "released".
   for (genvar gk = 0; gk < NUM_KEY; gk++) begin : g_key
      input_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (1'b1)
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .d_in  (key_in[gk]),
         .q_out (w_key_stable[gk])
      );
   end

   assign key_pressed = ~w_key_stable;

`ifdef SWITCH_INPUT_EVENT_LATCH_EN
   logic [NUM_KEY-1:0] r_key_prev;
   logic [NUM_KEY-1:0] r_key_event;
   logic [NUM_KEY-1:0] w_key_rise;
   logic               w_evt_clear;

   assign w_key_rise  = key_pressed & ~r_key_prev;
   assign w_evt_clear = rd_en && (rd_sel == SEL_EVENT);

   // A new press in the clearing cycle survives the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_prev  <= '0;
         r_key_event <= '0;
      end else begin
         r_key_prev <= key_pressed;
         if (w_evt_clear) r_key_event <= w_key_rise;
         else             r_key_event <= r_key_event | w_key_rise;
      end
   end

   assign w_key_event = r_key_event;
`else
   assign w_key_event = '0;
`endif

   always_comb begin
      w_rd_mux = '0;
      case (rd_sel)
         SEL_SW:    w_rd_mux[NUM_SW-1:0]  = sw_stable;
         SEL_KEY:   w_rd_mux[NUM_KEY-1:0] = key_pressed;
         SEL_EVENT: w_rd_mux[NUM_KEY-1:0] = w_key_event;
         default:   w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_rd_data <= '0;
      else if (rd_en) r_rd_data <= w_rd_mux;
   end

   assign rd_data = r_rd_data;

endmodule

// File: tb/tb_switch_input_controller.sv
// Directed bench for switch_input_controller with DEBOUNCE_CYCLES=4; read
// responses go through an expected-value queue checked by a separate monitor.
module tb_switch_input_controller;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  sw_in;
   logic [1:0]  key_in;
   logic        rd_en;
   logic [1:0]  rd_sel;
   logic [31:0] rd_data;
   logic [9:0]  sw_stable;
   logic [1:0]  key_pressed;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   switch_input_controller #(.DEBOUNCE_CYCLES(D)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sw_in       (sw_in),
      .key_in      (key_in),
      .rd_en       (rd_en),
      .rd_sel      (rd_sel),
      .rd_data     (rd_data),
      .sw_stable   (sw_stable),
      .key_pressed (key_pressed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input logic [1:0] sel, input logic [31:0] exp);
      rd_en  = 1'b1;
      rd_sel = sel;
      exp_q.push_back(exp);
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   // Monitor: each sampled read strobe must yield the next queued value.
   always @(posedge clk) begin
      if (rst_n === 1'b1 && rd_en === 1'b1) begin
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got 0x%08h expected no read", rd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("rd_data", rd_data, mon_exp);
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      sw_in  = 10'h3FF;
      key_in = 2'b00;
      rd_en  = 1'b0;
      rd_sel = 2'd0;
      cyc(3);
      chk("rst_sw_stable", 32'(sw_stable), 32'h0);
      chk("rst_key_pressed", 32'(key_pressed), 32'h0);
      chk("rst_rd_data", rd_data, 32'h0);

      // Release reset with inputs already asserted
      rst_n = 1'b1;
      cyc(5);
      chk("rel_sw_edge5", 32'(sw_stable), 32'h0);
      cyc(1);
      chk("rel_sw_edge6", 32'(sw_stable), 32'h3FF);
      chk("rel_key_edge6", 32'(key_pressed), 32'h3);
      rd(2'd0, 32'h3FF);
      rd(2'd1, 32'h3);
`ifdef SWITCH_INPUT_EVENT_LATCH_EN
      rd(2'd2, 32'h3);
`else
      rd(2'd2, 32'h0);
`endif
      key_in = 2'b11;
      cyc(10);
      chk("keys_released", 32'(key_pressed), 32'h0);
      rd(2'd2, 32'h0);

      // Latency
      sw_in = 10'h000;
      cyc(10);
      chk("sw_cleared", 32'(sw_stable), 32'h0);
      sw_in = 10'h2A5;
      cyc(5);
      chk("lat_edge5", 32'(sw_stable), 32'h0);
      cyc(1);
      chk("lat_edge6", 32'(sw_stable), 32'h2A5);
      rd(2'd0, 32'h0000_02A5);
      rd_sel = 2'd3;
      sw_in  = 10'h000;
      cyc(3);
      chk("rd_hold", rd_data, 32'h0000_02A5);
      cyc(10);
      chk("sw_back_0", 32'(sw_stable), 32'h0);

      // Glitch of 3 cycles must be rejected
      sw_in = 10'h001;
      cyc(3);
      sw_in = 10'h000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("glitch_sw0", 32'(sw_stable[0]), 32'h0);
      end

      // Pulse of exactly 4 cycles is just long enough
      sw_in = 10'h002;
      cyc(4);
      sw_in = 10'h000;
      cyc(1);
      chk("pulse4_edge5", 32'(sw_stable), 32'h0);
      cyc(1);
      chk("pulse4_edge6", 32'(sw_stable), 32'h2);
      cyc(10);
      chk("pulse4_return", 32'(sw_stable), 32'h0);

      // Reset mid-debounce discards the partial count
      sw_in = 10'h3FF;
      cyc(4);
      rst_n = 1'b0;
      cyc(2);
      chk("midrst_sw", 32'(sw_stable), 32'h0);
      chk("midrst_rd", rd_data, 32'h0);
      rst_n = 1'b1;
      cyc(5);
      chk("midrst_edge5", 32'(sw_stable), 32'h0);
      cyc(1);
      chk("midrst_edge6", 32'(sw_stable), 32'h3FF);
      sw_in = 10'h000;
      cyc(10);

`ifdef SWITCH_INPUT_EVENT_LATCH_EN
      key_in = 2'b10;
      cyc(8);
      chk("evt_key0_pressed", 32'(key_pressed), 32'h1);
      rd(2'd1, 32'h1);
      cyc(1);
      key_in = 2'b11;
      cyc(10);
      chk("evt_key0_released", 32'(key_pressed), 32'h0);
      rd(2'd2, 32'h1);
      rd(2'd2, 32'h0);

      // Simultaneous set (key 1) and clear
      key_in = 2'b10;
      cyc(10);
      key_in = 2'b11;
      cyc(10);
      key_in = 2'b01;
      begin
         int n = 0;
         while (key_pressed[1] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("evt_key1_rise_seen", 32'(key_pressed[1]), 32'h1);
      end
      rd(2'd2, 32'h1);
      rd(2'd2, 32'h2);
      key_in = 2'b11;
      cyc(10);
`else
      key_in = 2'b10;
      cyc(10);
      chk("noevt_key0_pressed", 32'(key_pressed), 32'h1);
      rd(2'd2, 32'h0);
      rd(2'd1, 32'h1);
      key_in = 2'b11;
      cyc(10);
`endif
      rd(2'd3, 32'h0);
      cyc(2);

      begin
         int n = 0;
         while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rd_missing: got %0d pending reads expected 0", exp_q.size());
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_input_controller.md
SWITCH_INPUT_CONTROLLER -- requirements
Module: switch_input_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the cycles an input must stay stable before it is accepted; legal values are 2 or more.
REQ-002 clk  input  1  the single clock; all flops SHALL be on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sw_in  input  10  raw slide switches, asynchronous, active-high.
REQ-005 key_in  input  2  raw push buttons, asynchronous, active-low.
REQ-006 rd_en  input  1  read strobe from the processor bus.
REQ-007 rd_sel  input  2  register select: 0 = switch state, 1 = key state, 2 = key events, 3 = reserved.
REQ-008 rd_data  output  32  registered read data.
REQ-009 sw_stable  output  10  debounced switch levels.
REQ-010 key_pressed  output  2  debounced key state, active-high (1 = pressed).

Function
REQ-011 Each of the 12 inputs SHALL pass through a 2-flop synchroniser and then through its own debounce counter.
REQ-012 Counter behaviour: when synchronised ≠ stable, the counter SHALL increment each cycle; when they are equal, it SHALL clear to 0.
REQ-013 When synchronised ≠ stable and the counter equals DEBOUNCE_CYCLES-1, stable SHALL take the synchronised value and the counter SHALL clear.
REQ-014 An input held constant SHALL update stable on the (DEBOUNCE_CYCLES+2)th rising edge after the raw change is first sampled.
REQ-015 A pulse shorter than DEBOUNCE_CYCLES synchronised cycles SHALL NOT change stable.
REQ-016 The counter width SHALL be $clog2(DEBOUNCE_CYCLES), and the counter SHALL never wrap.
REQ-017 key_pressed[i] SHALL equal the inverse of the debounced key_in[i].
REQ-018 The read data path SHALL have one cycle of latency: a read with rd_en=1 sampled at edge N SHALL drive rd_data from edge N onward, holding it until the next read.
REQ-019 Read data SHALL be zero-extended to 32 bits: sel 0 → sw_stable, sel 1 → key_pressed, sel 2 → key_event, sel 3 → 0.
REQ-020 When rd_en=0, rd_data SHALL hold its previous value.

Reset
REQ-021 While rst_n=0, the following SHALL be set: switch synchroniser/stable flops to 0, key synchroniser/stable flops to 1 (released), all counters to 0, key_event to 0, rd_data to 0.
REQ-022 Consequently, after reset sw_stable=0 and key_pressed=0.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count; the input SHALL need the full DEBOUNCE_CYCLES+2 again after rst_n rises.

Configuration
REQ-024 With macro SWITCH_INPUT_EVENT_LATCH_EN defined, the block SHALL include a 2-bit sticky register key_event.
- key_event[i] SHALL set on the cycle key_pressed[i] goes 0→1.
- All of key_event SHALL clear on a read with rd_sel=2.
- rd_data SHALL return the pre-clear value.
- If a set and a clear land in the same cycle, the set SHALL win for that bit.
REQ-025 Without SWITCH_INPUT_EVENT_LATCH_EN, no key_event storage or edge detection SHALL exist, and a read with rd_sel=2 SHALL return 0.

Structure
REQ-026 Package switch_input_pkg SHALL hold:
- NUM_SW=10 and NUM_KEY=2;
- the rd_sel constants SEL_SW=0, SEL_KEY=1, SEL_EVENT=2;
- the default DEBOUNCE_CYCLES.
REQ-027 Sub-module input_debouncer (1 bit, parameters DEBOUNCE_CYCLES and RESET_VAL; contains the synchroniser, counter and stable flop) SHALL be instantiated 12 times.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset: hold rst_n=0 with sw_in=0x3FF and key_in=0 → sw_stable=0, key_pressed=0, rd_data=0; after release, read sel 0 on the 6th edge → 0x3FF.
REQ-029 Latency: sw_in 0→0x2A5, held → sw_stable stays 0 for 5 edges and becomes 0x2A5 on edge 6; read sel 0 → rd_data=0x000002A5.
REQ-030 Glitch: sw_in[0] high for 3 cycles then low → sw_stable[0] stays 0 throughout.
REQ-031 Events (macro defined): key_in[0] low for 10 cycles → key_pressed=0x1; read sel 2 → 0x1; immediate second read sel 2 → 0x0.
REQ-032 Simultaneous events (macro defined): key_pressed[1] rises in the same cycle as a read with sel 2 → that read returns the old value and key_event[1]=1 afterwards.
REQ-033 Macro undefined: press key 0 and read sel 2 → 0; read sel 3 → 0 in both builds.
